// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch controller state (IDLE / REQ / DROP)
//   INSTR_W       : instruction word width
//   PC_STEP       : byte increment between consecutive instruction words
//   DEFAULT_DEPTH : default number of fetch queue entries
// ----------------------------------------------------------------------------
package ifetch_pkg;

   localparam int INSTR_W       = 32;
   localparam int PC_STEP       = 4;
   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,   // no request outstanding
      REQ  = 2'd1,   // request outstanding, data will be kept
      DROP = 2'd2    // request outstanding, data is stale and will be discarded
   } fetch_state_e;

endpackage

// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
// Synchronous FIFO of {pc, instruction} pairs with a registered head.
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   push_i/push_pc_i/push_instr_i : write a new entry (ignored when full)
//   pop_i                   : remove the head entry (ignored when empty)
//   flush_i                 : discard all entries (wins over push/pop)
//   count_o, full_o, empty_o: occupancy status
//   head_valid_o/head_pc_o/head_instr_o : registered head of the queue
// ----------------------------------------------------------------------------
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int  DEPTH  = DEFAULT_DEPTH,
   parameter int  ADDR_W = 32,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               push_i,
   input  logic [ADDR_W-1:0]  push_pc_i,
   input  logic [INSTR_W-1:0] push_instr_i,
   input  logic               pop_i,
   input  logic               flush_i,
   output logic [CNT_W-1:0]   count_o,
   output logic               full_o,
   output logic               empty_o,
   output logic               head_valid_o,
   output logic [ADDR_W-1:0]  head_pc_o,
   output logic [INSTR_W-1:0] head_instr_o
);

   logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];
   logic [INSTR_W-1:0] instr_mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d, count_left_s;
   logic               head_valid_q, head_valid_d;
   logic [ADDR_W-1:0]  head_pc_q, head_pc_d;
   logic [INSTR_W-1:0] head_instr_q, head_instr_d;
   logic               push_ok_s, pop_ok_s;

   assign full_o       = (count_q == CNT_W'(DEPTH));
   assign empty_o      = (count_q == {CNT_W{1'b0}});
   assign count_o      = count_q;
   assign head_valid_o = head_valid_q;
   assign head_pc_o    = head_pc_q;
   assign head_instr_o = head_instr_q;

   // Pointer/occupancy update and selection of the next registered head
   always_comb begin
      push_ok_s    = push_i && !full_o && !flush_i;
      pop_ok_s     = pop_i && !empty_o && !flush_i;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_left_s = count_q;
      count_d      = count_q;
      head_valid_d = head_valid_q;
      head_pc_d    = head_pc_q;
      head_instr_d = head_instr_q;
      if (flush_i) begin
         wr_ptr_d     = {PTR_W{1'b0}};
         rd_ptr_d     = {PTR_W{1'b0}};
         count_d      = {CNT_W{1'b0}};
         head_valid_d = 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_left_s = count_q - CNT_W'(pop_ok_s);
         count_d      = count_left_s + CNT_W'(push_ok_s);
         if (count_d == {CNT_W{1'b0}}) begin
            head_valid_d = 1'b0;
         end else if (count_left_s == {CNT_W{1'b0}}) begin
            // Only the word being written now will be in the queue: bypass it
            head_valid_d = 1'b1;
            head_pc_d    = push_pc_i;
            head_instr_d = push_instr_i;
         end else begin
            head_valid_d = 1'b1;
            head_pc_d    = pc_mem_q[rd_ptr_d];
            head_instr_d = instr_mem_q[rd_ptr_d];
         end
      end
   end

   // Control and head registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         count_q      <= {CNT_W{1'b0}};
         head_valid_q <= 1'b0;
         head_pc_q    <= {ADDR_W{1'b0}};
         head_instr_q <= {INSTR_W{1'b0}};
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_valid_q <= head_valid_d;
         head_pc_q    <= head_pc_d;
         head_instr_q <= head_instr_d;
      end
   end

   // Entry storage; occupancy gates every read, so contents need no reset
   always_ff @(posedge clk_i) begin
      if (push_ok_s) begin
         pc_mem_q[wr_ptr_q]    <= push_pc_i;
         instr_mem_q[wr_ptr_q] <= push_instr_i;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// ----------------------------------------------------------------------------
// ifetch_unit
// Instruction fetch stage: owns the PC, issues one word read at a time over
// a req/ack handshake, queues returned words with their PC and hands them to
// the execute core over valid/ready. A redirect flushes the queue and
// restarts fetch; a read still in flight at that moment is discarded.
// Ports:
//   clk, reset (synchronous, active high), head_address (PC after reset)
//   mem_req/mem_addr/mem_ack/mem_rdata : memory read handshake
//   ins_valid/instruction/ins_pc/ins_ready : registered queue head to core
//   redirect/redirect_pc : flush and restart fetch at redirect_pc
//   fault : sticky misaligned-redirect flag (only with IFETCH_ALIGN_FAULT_EN)
// Build option: IFETCH_ALIGN_FAULT_EN. Without it the two low bits of
// redirect_pc are truncated; with it a misaligned redirect halts fetch.
// ----------------------------------------------------------------------------
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  head_address,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               ins_valid,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  ins_pc,
   input  logic               ins_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFETCH_ALIGN_FAULT_EN
   ,
   output logic               fault
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] redirect_pc_s;
   logic              halt_s, misalign_s;
   logic              q_push_s, q_pop_s, q_full_s, q_empty_s;
   logic [CNT_W-1:0]  q_count_s, count_next_s;

`ifdef IFETCH_ALIGN_FAULT_EN
   logic fault_q;

   assign halt_s        = fault_q;
   assign misalign_s    = redirect && (redirect_pc[1:0] != 2'b00);
   assign redirect_pc_s = redirect_pc;
   assign fault         = fault_q;

   // Sticky alignment fault, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         fault_q <= 1'b0;
      end else if (misalign_s) begin
         fault_q <= 1'b1;
      end else begin
         fault_q <= fault_q;
      end
   end
`else
   assign halt_s        = 1'b0;
   assign misalign_s    = 1'b0;
   assign redirect_pc_s = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

   assign mem_req  = (state_q != IDLE);
   assign mem_addr = addr_q;

   // Queue control: a redirect flushes and swallows both the ack and the pop
   always_comb begin
      q_pop_s  = ins_valid && ins_ready && !q_empty_s && !redirect;
      q_push_s = (state_q == REQ) && mem_ack && !redirect && !q_full_s;
      if (redirect) begin
         count_next_s = {CNT_W{1'b0}};
      end else begin
         count_next_s = q_count_s + CNT_W'(q_push_s) - CNT_W'(q_pop_s);
      end
   end

   // Fetch FSM next state, next PC and next request address
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      if (halt_s) begin
         state_d = IDLE;
      end else if (redirect) begin
         fetch_pc_d = redirect_pc_s;
         if (misalign_s) begin
            state_d = IDLE;
         end else if ((state_q != IDLE) && !mem_ack) begin
            // Old read still in flight: wait it out and discard its data
            state_d = DROP;
         end else begin
            state_d = REQ;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (count_next_s < CNT_W'(DEPTH)) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
            REQ: begin
               if (mem_ack) begin
                  fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
               end else begin
                  fetch_pc_d = fetch_pc_q;
               end
               // Only keep requesting while a slot is guaranteed for the data
               if (count_next_s < CNT_W'(DEPTH)) begin
                  state_d = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
            DROP: begin
               if (mem_ack) begin
                  state_d = REQ;
               end else begin
                  state_d = DROP;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      // A new request starts whenever REQ is entered or a read completes in REQ;
      // otherwise the address is held so it stays stable while mem_req is high
      if ((state_d == REQ) && ((state_q != REQ) || mem_ack)) begin
         addr_d = fetch_pc_d;
      end else begin
         addr_d = addr_q;
      end
   end

   // Fetch state, PC and request address registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= REQ;
         fetch_pc_q <= head_address;
         addr_q     <= head_address;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
      end
   end

   ifetch_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_queue (
      .clk_i        (clk),
      .reset_i      (reset),
      .push_i       (q_push_s),
      .push_pc_i    (fetch_pc_q),
      .push_instr_i (mem_rdata),
      .pop_i        (q_pop_s),
      .flush_i      (redirect),
      .count_o      (q_count_s),
      .full_o       (q_full_s),
      .empty_o      (q_empty_s),
      .head_valid_o (ins_valid),
      .head_pc_o    (ins_pc),
      .head_instr_o (instruction)
   );

endmodule
